// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the 5-stage MIPS pipeline.
// Owns the pipeline-register enables/clears, the PC enable, the run/halt
// state driven by a WB syscall and the resume button, the LED display
// register and four 32-bit performance counters.
module pipe_hazard_ctrl #(
  parameter logic [31:0] LED_CODE = 32'd34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        ex_mem_to_reg,
  input  logic        r1_ex_related,
  input  logic        r2_ex_related,
  input  logic        ex_branch_taken,
  input  logic        ex_jump,
  input  logic        wb_effective,
  input  logic        wb_syscall,
  input  logic [31:0] wb_r1_data,
  input  logic [31:0] wb_r2_data,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        ifid_rst,
  output logic        idex_enable,
  output logic        idex_rst,
  output logic        exmem_enable,
  output logic        memwb_enable,
  output logic        halted,
  output logic        led_cpu_enable,
  output logic [31:0] led_data_in,
  output logic [31:0] total_cycles,
  output logic [31:0] bubble_num,
  output logic [31:0] condi_branch_num,
  output logic [31:0] uncondi_branch_num
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic        go_q, go_d;
  logic [31:0] led_q, led_d;
  logic [31:0] total_cycles_q, total_cycles_d;
  logic [31:0] bubble_num_q, bubble_num_d;
  logic [31:0] condi_q, condi_d;
  logic [31:0] uncondi_q, uncondi_d;

  logic go_rise;
  logic halt_req;
  logic led_req;
  logic freeze;
  logic flush;
  logic load_use;
  logic stall;

  // Hazard and halt status derived from the current stage inputs and state.
  always_comb begin
    go_rise  = go & ~go_q;
    halt_req = wb_effective & wb_syscall & (wb_r1_data != LED_CODE);
    led_req  = wb_effective & wb_syscall & (wb_r1_data == LED_CODE);
    freeze   = ((state_q == HALT) & ~go_rise) | ((state_q == RUN) & halt_req);
    flush    = ex_branch_taken | ex_jump;
    load_use = ex_mem_to_reg & (r1_ex_related | r2_ex_related);
    // A squashed ID instruction needs no stall, so flush takes priority.
    stall    = load_use & ~flush;
  end

  // Zero-latency pipeline enables and clears.
  always_comb begin
    pc_enable      = ~freeze & ~stall;
    ifid_enable    = ~freeze & ~stall;
    ifid_rst       = rst | (~freeze & flush);
    idex_enable    = ~freeze;
    idex_rst       = rst | (~freeze & (flush | stall));
    exmem_enable   = ~freeze;
    memwb_enable   = ~freeze;
    led_cpu_enable = led_req & ~freeze;
  end

  // Next-state for the run/halt FSM, LED register and counters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (go_rise)  state_d = RUN;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALT);
    go_d     = go;

    led_d = led_q;
    if (led_req & ~freeze) led_d = wb_r2_data;

    total_cycles_d = total_cycles_q;
    bubble_num_d   = bubble_num_q;
    condi_d        = condi_q;
    uncondi_d      = uncondi_q;
    if (~freeze) begin
      total_cycles_d = total_cycles_q + 32'd1;
      if (stall)           bubble_num_d = bubble_num_q + 32'd1;
      if (ex_branch_taken) condi_d      = condi_q + 32'd1;
      if (ex_jump)         uncondi_d    = uncondi_q + 32'd1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      halted_q       <= 1'b0;
      go_q           <= 1'b0;
      led_q          <= 32'd0;
      total_cycles_q <= 32'd0;
      bubble_num_q   <= 32'd0;
      condi_q        <= 32'd0;
      uncondi_q      <= 32'd0;
    end else begin
      state_q        <= state_d;
      halted_q       <= halted_d;
      go_q           <= go_d;
      led_q          <= led_d;
      total_cycles_q <= total_cycles_d;
      bubble_num_q   <= bubble_num_d;
      condi_q        <= condi_d;
      uncondi_q      <= uncondi_d;
    end
  end

  assign halted             = halted_q;
  assign led_data_in        = led_q;
  assign total_cycles       = total_cycles_q;
  assign bubble_num         = bubble_num_q;
  assign condi_branch_num   = condi_q;
  assign uncondi_branch_num = uncondi_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, flushes, LED syscall,
// halt/resume with go edge detection, counter wrap and reset from HALT.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        ex_mem_to_reg;
  logic        r1_ex_related;
  logic        r2_ex_related;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        wb_effective;
  logic        wb_syscall;
  logic [31:0] wb_r1_data;
  logic [31:0] wb_r2_data;
  logic        pc_enable;
  logic        ifid_enable;
  logic        ifid_rst;
  logic        idex_enable;
  logic        idex_rst;
  logic        exmem_enable;
  logic        memwb_enable;
  logic        halted;
  logic        led_cpu_enable;
  logic [31:0] led_data_in;
  logic [31:0] total_cycles;
  logic [31:0] bubble_num;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LED_CODE(32'd34)) dut (
    .clk(clk), .rst(rst), .go(go),
    .ex_mem_to_reg(ex_mem_to_reg),
    .r1_ex_related(r1_ex_related), .r2_ex_related(r2_ex_related),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .wb_effective(wb_effective), .wb_syscall(wb_syscall),
    .wb_r1_data(wb_r1_data), .wb_r2_data(wb_r2_data),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_rst(ifid_rst),
    .idex_enable(idex_enable), .idex_rst(idex_rst),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .halted(halted), .led_cpu_enable(led_cpu_enable), .led_data_in(led_data_in),
    .total_cycles(total_cycles), .bubble_num(bubble_num),
    .condi_branch_num(condi_branch_num), .uncondi_branch_num(uncondi_branch_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    go = 1'b0; ex_mem_to_reg = 1'b0; r1_ex_related = 1'b0; r2_ex_related = 1'b0;
    ex_branch_taken = 1'b0; ex_jump = 1'b0; wb_effective = 1'b0; wb_syscall = 1'b0;
    wb_r1_data = 32'd0; wb_r2_data = 32'd0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_ifid_rst", {31'd0, ifid_rst}, 32'd1);
    chk("rst_idex_rst", {31'd0, idex_rst}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_total", total_cycles, 32'd0);
    chk("reset_led", led_data_in, 32'd0);
    chk("idle_pc_en", {31'd0, pc_enable}, 32'd1);
    chk("idle_ifid_rst", {31'd0, ifid_rst}, 32'd0);
    chk("idle_idex_rst", {31'd0, idex_rst}, 32'd0);
    tick();
    chk("idle_total", total_cycles, 32'd1);

    // load-use on R1: one bubble
    ex_mem_to_reg = 1'b1; r1_ex_related = 1'b1;
    #1;
    chk("lu_pc_en", {31'd0, pc_enable}, 32'd0);
    chk("lu_ifid_en", {31'd0, ifid_enable}, 32'd0);
    chk("lu_idex_rst", {31'd0, idex_rst}, 32'd1);
    chk("lu_idex_en", {31'd0, idex_enable}, 32'd1);
    tick();
    chk("lu_bubble", bubble_num, 32'd1);
    chk("lu_total", total_cycles, 32'd2);

    // load-use on R2
    r1_ex_related = 1'b0; r2_ex_related = 1'b1;
    #1;
    chk("lu2_pc_en", {31'd0, pc_enable}, 32'd0);
    tick();
    chk("lu2_bubble", bubble_num, 32'd2);

    // related but not a load: no stall
    ex_mem_to_reg = 1'b0; r1_ex_related = 1'b1; r2_ex_related = 1'b0;
    #1;
    chk("nold_pc_en", {31'd0, pc_enable}, 32'd1);
    chk("nold_idex_rst", {31'd0, idex_rst}, 32'd0);
    tick();
    chk("nold_total", total_cycles, 32'd4);

    // taken branch while load_use: flush wins
    ex_mem_to_reg = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_rst", {31'd0, ifid_rst}, 32'd1);
    chk("br_idex_rst", {31'd0, idex_rst}, 32'd1);
    chk("br_pc_en", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("br_bubble", bubble_num, 32'd2);
    chk("br_condi", condi_branch_num, 32'd1);

    // jump
    ex_mem_to_reg = 1'b0; r1_ex_related = 1'b0; ex_branch_taken = 1'b0; ex_jump = 1'b1;
    #1;
    chk("j_ifid_rst", {31'd0, ifid_rst}, 32'd1);
    tick();
    chk("j_uncondi", uncondi_branch_num, 32'd1);

    // illegal branch+jump: both count
    ex_branch_taken = 1'b1;
    tick();
    chk("bj_condi", condi_branch_num, 32'd2);
    chk("bj_uncondi", uncondi_branch_num, 32'd2);
    chk("bj_total", total_cycles, 32'd7);

    // LED syscall
    idle_inputs();
    wb_effective = 1'b1; wb_syscall = 1'b1; wb_r1_data = 32'd34; wb_r2_data = 32'h1234;
    #1;
    chk("led_strobe", {31'd0, led_cpu_enable}, 32'd1);
    chk("led_pc_en", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("led_data", led_data_in, 32'h1234);
    chk("led_halted", {31'd0, halted}, 32'd0);
    chk("led_total", total_cycles, 32'd8);

    // syscall not effective: ignored
    wb_effective = 1'b0; wb_r1_data = 32'd10; wb_r2_data = 32'h0;
    #1;
    chk("ineff_strobe", {31'd0, led_cpu_enable}, 32'd0);
    chk("ineff_pc_en", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("ineff_halted", {31'd0, halted}, 32'd0);

    // halting syscall, with a simultaneous go edge and jump
    wb_effective = 1'b1; go = 1'b1; ex_jump = 1'b1;
    #1;
    chk("h_pc_en", {31'd0, pc_enable}, 32'd0);
    chk("h_idex_en", {31'd0, idex_enable}, 32'd0);
    chk("h_exmem_en", {31'd0, exmem_enable}, 32'd0);
    chk("h_memwb_en", {31'd0, memwb_enable}, 32'd0);
    chk("h_ifid_rst", {31'd0, ifid_rst}, 32'd0);
    tick();
    chk("h_halted", {31'd0, halted}, 32'd1);
    chk("h_total", total_cycles, 32'd9);
    chk("h_uncondi", uncondi_branch_num, 32'd2);
    go = 1'b0; ex_jump = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_halted", {31'd0, halted}, 32'd1);
    chk("hold_total", total_cycles, 32'd9);
    chk("hold_pc_en", {31'd0, pc_enable}, 32'd0);

    // LED request while halted is suppressed
    wb_r1_data = 32'd34; wb_r2_data = 32'hBEEF;
    #1;
    chk("hled_strobe", {31'd0, led_cpu_enable}, 32'd0);
    tick();
    chk("hled_data", led_data_in, 32'h1234);
    wb_r1_data = 32'd10; wb_r2_data = 32'd0;

    // resume: single advance, then a new halting syscall while go stays high
    go = 1'b1;
    #1;
    chk("res_pc_en", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("res_halted", {31'd0, halted}, 32'd0);
    chk("res_total", total_cycles, 32'd10);
    chk("rehalt_pc_en", {31'd0, pc_enable}, 32'd0);
    tick();
    chk("rehalt_halted", {31'd0, halted}, 32'd1);
    tick();
    chk("heldgo_halted", {31'd0, halted}, 32'd1);
    chk("heldgo_total", total_cycles, 32'd10);
    go = 1'b0;
    tick();
    chk("golow_total", total_cycles, 32'd10);
    go = 1'b1;
    tick();
    chk("res2_halted", {31'd0, halted}, 32'd0);
    chk("res2_total", total_cycles, 32'd11);
    idle_inputs();

    // counter wrap
    force dut.total_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.total_cycles_q;
    #1;
    chk("wrap_pre", total_cycles, 32'hFFFF_FFFF);
    tick();
    chk("wrap_post", total_cycles, 32'h0000_0000);

    // halt, then reset while halted
    wb_effective = 1'b1; wb_syscall = 1'b1; wb_r1_data = 32'd10;
    tick();
    chk("rh_halted", {31'd0, halted}, 32'd1);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rh_halted_clr", {31'd0, halted}, 32'd0);
    chk("rh_total", total_cycles, 32'd0);
    chk("rh_bubble", bubble_num, 32'd0);
    chk("rh_condi", condi_branch_num, 32'd0);
    chk("rh_uncondi", uncondi_branch_num, 32'd0);
    chk("rh_led", led_data_in, 32'd0);
    chk("rh_pc_en", {31'd0, pc_enable}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS pipeline CPU. It owns every pipeline-register enable and clear, the PC enable, and the run/halt state driven by `syscall` in WB and the `go` button. It also owns the LED display register and the four 32-bit performance counters: total cycles, bubbles, conditional branches taken, unconditional jumps. It sits beside the datapath, takes hazard/branch/syscall status from ID, EX and WB, and returns only control and statistics.

## Interface
Parameters:
- LED_CODE, 34: `$v0` (WB R1 data) value that makes a WB `syscall` a display request instead of a halt.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  level input from resume button; only its rising edge is used
- ex_mem_to_reg  in  1  instruction in EX is a load
- r1_ex_related  in  1  ID R1 source matches EX destination and is used
- r2_ex_related  in  1  ID R2 source matches EX destination and is used
- ex_branch_taken  in  1  conditional branch in EX resolved taken
- ex_jump  in  1  j/jal/jr in EX (redirects PC)
- wb_effective  in  1  WB holds a valid, non-bubble instruction
- wb_syscall  in  1  WB instruction is `syscall`
- wb_r1_data  in  32  `$v0` value of WB `syscall`
- wb_r2_data  in  32  `$a0` value of WB `syscall`
- pc_enable  out  1  PC load enable
- ifid_enable, ifid_rst  out  1 each  IF/ID enable, synchronous clear
- idex_enable, idex_rst  out  1 each  ID/EX enable, synchronous clear
- exmem_enable, memwb_enable  out  1 each  EX/MEM, MEM/WB enables
- halted  out  1  registered, 1 while in HALT
- led_cpu_enable  out  1  combinational display strobe
- led_data_in  out  32  registered LED value
- total_cycles, bubble_num, condi_branch_num, uncondi_branch_num  out  32 each  counters

## Operation
Internal derived signals:
- go_rise = go & ~go_q, where go_q is `go` registered (reset 0).
- halt_req = wb_effective & wb_syscall & (wb_r1_data != LED_CODE).
- led_req = wb_effective & wb_syscall & (wb_r1_data == LED_CODE).
- freeze = (state==HALT & ~go_rise) | (state==RUN & halt_req).
- flush = ex_branch_taken | ex_jump.
- load_use = ex_mem_to_reg & (r1_ex_related | r2_ex_related).
- stall = load_use & ~flush. Flush wins because the dependent ID instruction is squashed anyway.

Pipeline control outputs:
- pc_enable = ifid_enable = ~freeze & ~stall.
- ifid_rst = rst | (~freeze & flush).
- idex_enable = exmem_enable = memwb_enable = ~freeze.
- idex_rst = rst | (~freeze & (flush | stall)). This inserts the bubble or squashes the instruction.

State machine (2 states, reset RUN):
- RUN -> HALT when halt_req. The pipeline freezes in that same cycle, so the halting `syscall` stays in WB.
- HALT -> RUN on go_rise. That cycle freeze=0, the pipeline advances one step and the `syscall` leaves WB.
- halt_req is ignored in HALT. `go` in RUN has no effect.

LED:
- led_cpu_enable = led_req & ~freeze.
- When led_cpu_enable is 1, led_data_in <= wb_r2_data.

Counters (each increments by 1, wraps 0xFFFFFFFF -> 0, never saturates):
- total_cycles: when ~freeze.
- bubble_num: when stall & ~freeze.
- condi_branch_num: when ex_branch_taken & ~freeze.
- uncondi_branch_num: when ex_jump & ~freeze.

## Timing
- Reset: state RUN, halted 0, go_q 0, led_data_in 0, all counters 0. ifid_rst and idex_rst are 1 during rst.
- All enable/clear outputs are combinational from the current inputs and state, with zero latency. Registers and counters update on the next clock edge.
- Halt entry: freeze is asserted in the cycle halt_req first rises; halted goes 1 on the following edge. total_cycles does not count that cycle.
- Resume: exactly one go_rise is needed. Holding `go` high gives one advance only; a new rising edge is needed for the next halt.
- A go_rise in the same cycle the halting `syscall` arrives (state RUN) does not cancel the halt.
- Load-use stall lasts exactly 1 cycle, because the load leaves EX after that cycle.
- Simultaneous flush and load_use: flush only; bubble_num is not incremented.
- Simultaneous ex_branch_taken and ex_jump never occur legally. If they do, both counters increment.
- rst asserted in HALT returns to RUN on the next edge, with counters and LED cleared.

## Test plan
- Load-use: `lw $1,0($0)` then `add $2,$1,$1` -> one cycle with pc_enable=0, ifid_enable=0, idex_rst=1; bubble_num 0->1; total_cycles counts that cycle.
- Taken `beq` in EX while load_use=1 -> ifid_rst=1, idex_rst=1, pc_enable=1, bubble_num unchanged, condi_branch_num +1.
- `syscall` in WB with wb_r1_data=34, wb_r2_data=0x1234 -> led_cpu_enable=1 for 1 cycle, led_data_in=0x1234 next cycle, halted stays 0.
- `syscall` in WB with wb_r1_data=10 -> all enables 0 that cycle, halted=1 next edge, counters frozen for 20 cycles. Then pulse `go` for 3 cycles -> exactly one advancing cycle, total_cycles +1, halted=0.
- Preload total_cycles to 0xFFFFFFFF by forcing counts, run 1 cycle -> 0x00000000. Assert rst while halted -> halted=0, all counters 0, led_data_in 0.
